// File: rtl/stress_frame_tx.sv
// UART-style (8N1, LSB first) frame transmitter: each accepted 16-bit sample
// is sent as sync byte, sample MSB, sample LSB and an XOR checksum byte.
module stress_frame_tx #(
  parameter int          CLKS_PER_BIT = 16,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        tx,
  output logic        busy,
  output logic [7:0]  frame_count
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

  state_t      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [15:0] data_q, data_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        in_ready_q, in_ready_d;
  logic [7:0]  frame_count_q, frame_count_d;

  logic [7:0]  cur_byte;
  logic [2:0]  next_bit_idx;
  logic        bit_last;

  always_comb begin
    cur_byte = SYNC_BYTE;
    case (byte_idx_q)
      2'd0: cur_byte = SYNC_BYTE;
      2'd1: cur_byte = data_q[15:8];
      2'd2: cur_byte = data_q[7:0];
      2'd3: cur_byte = data_q[15:8] ^ data_q[7:0];
      default: cur_byte = SYNC_BYTE;
    endcase
  end

  assign next_bit_idx = bit_idx_q + 3'd1;
  assign bit_last     = (timer_q == BIT_LAST);

  // Outputs are computed for the state being entered so they change on the
  // same edge as the state register and remain fully registered.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    bit_idx_d     = bit_idx_q;
    byte_idx_d    = byte_idx_q;
    data_d        = data_q;
    tx_d          = tx_q;
    busy_d        = busy_q;
    in_ready_d    = in_ready_q;
    frame_count_d = frame_count_q;

    case (state_q)
      IDLE: begin
        tx_d       = 1'b1;
        busy_d     = 1'b0;
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          data_d     = in_data;
          byte_idx_d = 2'd0;
          timer_d    = 16'd0;
          state_d    = START;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
          in_ready_d = 1'b0;
        end
      end
      START: begin
        timer_d = timer_q + 16'd1;
        if (bit_last) begin
          timer_d   = 16'd0;
          bit_idx_d = 3'd0;
          state_d   = DATA;
          tx_d      = cur_byte[0];
        end
      end
      DATA: begin
        timer_d = timer_q + 16'd1;
        if (bit_last) begin
          timer_d = 16'd0;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = next_bit_idx;
            tx_d      = cur_byte[next_bit_idx];
          end
        end
      end
      STOP: begin
        timer_d = timer_q + 16'd1;
        if (bit_last) begin
          timer_d = 16'd0;
          if (byte_idx_q == 2'd3) begin
            state_d       = IDLE;
            tx_d          = 1'b1;
            busy_d        = 1'b0;
            in_ready_d    = 1'b1;
            frame_count_d = frame_count_q + 8'd1;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            state_d    = START;
            tx_d       = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      timer_q       <= 16'd0;
      bit_idx_q     <= 3'd0;
      byte_idx_q    <= 2'd0;
      data_q        <= 16'd0;
      tx_q          <= 1'b1;
      busy_q        <= 1'b0;
      in_ready_q    <= 1'b0;
      frame_count_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      bit_idx_q     <= bit_idx_d;
      byte_idx_q    <= byte_idx_d;
      data_q        <= data_d;
      tx_q          <= tx_d;
      busy_q        <= busy_d;
      in_ready_q    <= in_ready_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign tx          = tx_q;
  assign busy        = busy_q;
  assign in_ready    = in_ready_q;
  assign frame_count = frame_count_q;

endmodule

// File: doc/stress_frame_tx.md
# stress_frame_tx

Serial frame transmitter for the stress-sensor tile. It accepts 16-bit sensor samples over a valid/ready handshake and sends each one off-chip as a 4-byte frame on a single UART-style line (8N1, LSB first, idle high): sync byte, sample MSB, sample LSB, checksum. It sits between the sensor measurement logic and a uio output pin inside the tile top level. It is the transmit end of the host-side frame receiver.

## Interface
Parameters:
- CLKS_PER_BIT, default 16: clock cycles per serial bit. Legal range is 2..65535.
- SYNC_BYTE, default 8'hA5: first byte of every frame.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset. There is one clock domain; reset is sampled only on the rising edge of clk.
- in_data  input  16  sample to send; captured on accept.
- in_valid  input  1  sample-present qualifier.
- in_ready  output  1  block can accept a sample this cycle.
- tx  output  1  serial line; idle high.
- busy  output  1  a frame is in progress.
- frame_count  output  8  number of completed frames, modulo 256.

## Operation
- States:
  - IDLE: tx=1, in_ready=1, busy=0.
  - START: tx=0.
  - DATA: tx = current byte bit, index 0..7, LSB first.
  - STOP: tx=1.
- Accept occurs when in_valid && in_ready at a rising edge. On accept:
  - latch in_data;
  - build the byte sequence B0=SYNC_BYTE, B1=in_data[15:8], B2=in_data[7:0], B3=B1^B2 (8-bit XOR);
  - set byte index to 0 and go to START.
- Every bit (start, 8 data, stop) lasts exactly CLKS_PER_BIT cycles. The bit-timer counter is wide enough for 65535.
- After the STOP bit of bytes B0..B2, go straight to START of the next byte. There is no inter-byte gap.
- After the STOP bit of B3:
  - go to IDLE;
  - increment frame_count, wrapping 255 -> 0.
- Outside IDLE, in_valid is ignored and in_data changes have no effect on the frame in flight.
- Reset (rst_n=0 at an edge), including in the middle of a frame:
  - state=IDLE, tx=1, busy=0, in_ready=0, frame_count=0;
  - any partial frame is abandoned with no stop bit completion.
- On the first edge with rst_n=1: in_ready=1.
- If in_valid=1 on that same first edge, no accept happens, because in_ready was 0.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Timing
- Let N=CLKS_PER_BIT and let E0 be the accept edge.
- At E0, in_ready becomes 0, busy becomes 1 and tx becomes 0 (start bit of B0).
- Bit k of the frame (k=0..39; byte j = k/10; position within the byte = k%10) drives tx from edge E0+k*N until edge E0+(k+1)*N.
  - Position 0 is the start bit (0).
  - Positions 1..8 are data bits 0..7.
  - Position 9 is the stop bit (1).
- At edge E0+40N:
  - tx=1, busy=0, in_ready=1, frame_count+1.
- Earliest next accept is edge E0+40N+1, when in_valid is held high. Minimum frame period is 40N+1 cycles.
- Line-level throughput is 40N cycles per frame of line time plus one idle cycle between frames.

## Test plan
- Reset state: hold rst_n=0 for 5 cycles with in_valid=1 -> tx=1, busy=0, in_ready=0, frame_count=0 throughout. in_ready=1 one edge after release, and no accept on the release edge.
- Single frame, N=4: send in_data=16'h1234.
  - Sampling tx mid-bit decodes the bytes A5, 12, 34, 26.
  - busy is high for exactly 160 cycles.
  - frame_count=1 afterwards.
- Back-to-back, N=4: hold in_valid=1 with 16'h00FF, then 16'hFFFF.
  - Frames decode as A5,00,FF,FF and A5,FF,FF,00.
  - Second start bit begins exactly 161 cycles after the first.
- Input held during frame: change in_data and toggle in_valid mid-frame -> the frame in flight is unchanged and no extra accept happens.
- Reset mid-frame: assert rst_n=0 during the DATA bits of B1 -> tx=1 and busy=0 on the next edge, frame_count=0, and a following frame is sent correctly.
- Wrap: send 256 frames of 16'h0000 with N=2 -> frame_count reads 0 after the 256th frame and each frame is A5,00,00,00.
